// File: rtl/uart_rx.sv
// uart_rx: samples an asynchronous idle-high serial line into bytes on a valid/ready stream with parity/framing flags.
// Latency: 2 clk line synchroniser; rx_valid rises 1 clk after the last stop-bit sample (+1 clk with majority voting).
// Backpressure: single holding register; a byte completing while it is full and not being drained is dropped, sts_ovr pulses.
// Build option: define UART_RX_MAJORITY_EN for 3-point majority sampling of every bit (needs N_BIT >= 6).
module uart_rx #(
    parameter int    BYTESIZE = 8,
    parameter string PARITY   = "NONE",
    parameter int    STOPSIZE = 1,
    parameter int    N_BIT    = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                uart_rxd,
    output logic [BYTESIZE-1:0] rx_data,
    output logic                rx_perr,
    output logic                rx_ferr,
    output logic                rx_valid,
    input  logic                rx_ready,
    output logic                sts_ovr,
    output logic                sts_busy
);

    localparam int CW      = $clog2(N_BIT);
    localparam int BW      = $clog2(BYTESIZE);
    localparam bit HAS_PAR = (PARITY != "NONE");
    localparam bit ODD_PAR = (PARITY == "ODD");

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // line synchroniser plus one more stage for falling-edge detection
    logic rxd_meta_q;
    logic rxs_q;
    logic rxs_prev_q;

    // frame FSM state
    state_t                state_q,    state_d;
    logic [CW-1:0]         timer_q,    timer_d;
    logic [BW-1:0]         bit_cnt_q,  bit_cnt_d;
    logic                  stop_cnt_q, stop_cnt_d;
    logic [BYTESIZE-1:0]   shreg_q,    shreg_d;
    logic                  perr_q,     perr_d;
    logic                  ferr_q,     ferr_d;

    // output holding register
    logic [BYTESIZE-1:0]   rx_data_q,  rx_data_d;
    logic                  rx_perr_q,  rx_perr_d;
    logic                  rx_ferr_q,  rx_ferr_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  sts_ovr_q,  sts_ovr_d;

    // per-bit decision strobe and the bit value it decides on
    logic sample_tick;
    logic sample_bit;
    logic frame_done;
    logic accept;
    logic par_exp;

    // bring the asynchronous line into the clk domain; idle level is high
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rxd_meta_q <= 1'b1;
            rxs_q      <= 1'b1;
            rxs_prev_q <= 1'b1;
        end else begin
            rxd_meta_q <= uart_rxd;
            rxs_q      <= rxd_meta_q;
            rxs_prev_q <= rxs_q;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    // the three vote points need timer==1 to exist inside the start half-bit
    if (N_BIT < 6) begin : g_nbit_check
        $error("uart_rx: UART_RX_MAJORITY_EN requires N_BIT >= 6");
    end

    logic maj1_q;
    logic maj0_q;
    logic pend_q;

    // capture the line at timer==1 and timer==0; the vote and the FSM step happen one clk later
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            maj1_q <= 1'b1;
            maj0_q <= 1'b1;
            pend_q <= 1'b0;
        end else begin
            if (state_q != S_IDLE && timer_q == CW'(1)) begin
                maj1_q <= rxs_q;
            end
            if (state_q != S_IDLE && timer_q == '0) begin
                maj0_q <= rxs_q;
            end
            pend_q <= (state_q != S_IDLE) && (timer_q == '0);
        end
    end

    // 2-of-3 vote rejects a single-clk glitch near mid-bit
    always_comb begin
        sample_tick = pend_q;
        sample_bit  = (maj1_q & maj0_q) | (maj1_q & rxs_q) | (maj0_q & rxs_q);
    end
`else
    // one sample per bit, taken when the bit timer expires
    always_comb begin
        sample_tick = (state_q != S_IDLE) && (timer_q == '0);
        sample_bit  = rxs_q;
    end
`endif

    // FSM state and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            timer_q    <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            shreg_q    <= '0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            shreg_q    <= shreg_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
        end
    end

    // expected parity over the fully shifted-in data word
    always_comb begin
        par_exp = ODD_PAR ? ~^shreg_q : ^shreg_q;
    end

    // next-state: bit timing, shifting, error accumulation, frame completion
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        shreg_d    = shreg_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        frame_done = 1'b0;

        // free-running bit timer while a frame is in progress
        if (state_q != S_IDLE) begin
            timer_d = (timer_q == '0) ? CW'(N_BIT - 1) : timer_q - 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                // a held-low line (break) gives no edge, so it cannot re-arm until it goes high
                if (rxs_prev_q && !rxs_q) begin
                    state_d    = S_START;
                    timer_d    = CW'(N_BIT / 2 - 1);
                    bit_cnt_d  = '0;
                    stop_cnt_d = 1'b0;
                    perr_d     = 1'b0;
                    ferr_d     = 1'b0;
                end
            end
            S_START: begin
                if (sample_tick) begin
                    // high at mid start bit: glitch, drop silently
                    state_d = sample_bit ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (sample_tick) begin
                    shreg_d = {sample_bit, shreg_q[BYTESIZE-1:1]};
                    if (bit_cnt_q == BW'(BYTESIZE - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = HAS_PAR ? S_PARITY : S_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (sample_tick) begin
                    if (sample_bit != par_exp) begin
                        perr_d = 1'b1;
                    end
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (sample_tick) begin
                    if (!sample_bit) begin
                        ferr_d = 1'b1;
                    end
                    if (stop_cnt_q == 1'(STOPSIZE - 1)) begin
                        // finish mid stop bit so a following start edge is not missed
                        stop_cnt_d = 1'b0;
                        state_d    = S_IDLE;
                        frame_done = 1'b1;
                    end else begin
                        stop_cnt_d = stop_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // holding register: load on completion if empty or being drained, else flag overrun
    always_comb begin
        accept     = frame_done && (!rx_valid_q || rx_ready);
        rx_data_d  = rx_data_q;
        rx_perr_d  = rx_perr_q;
        rx_ferr_d  = rx_ferr_q;
        rx_valid_d = rx_valid_q;
        sts_ovr_d  = frame_done && !accept;

        if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end
        if (accept) begin
            rx_data_d  = shreg_q;
            rx_perr_d  = perr_q;
            rx_ferr_d  = ferr_d;
            rx_valid_d = 1'b1;
        end
    end

    // output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_data_q  <= '0;
            rx_perr_q  <= 1'b0;
            rx_ferr_q  <= 1'b0;
            rx_valid_q <= 1'b0;
            sts_ovr_q  <= 1'b0;
        end else begin
            rx_data_q  <= rx_data_d;
            rx_perr_q  <= rx_perr_d;
            rx_ferr_q  <= rx_ferr_d;
            rx_valid_q <= rx_valid_d;
            sts_ovr_q  <= sts_ovr_d;
        end
    end

    assign rx_data  = rx_data_q;
    assign rx_perr  = rx_perr_q;
    assign rx_ferr  = rx_ferr_q;
    assign rx_valid = rx_valid_q;
    assign sts_ovr  = sts_ovr_q;
    assign sts_busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames into uart_rx (8 data bits, odd parity, 1 stop bit) with checks on every reported byte.
// Latency: checks are taken after a fixed idle gap that covers sync + sampling + completion delay.
// Backpressure: rx_ready held high except for the overrun scenario.
module tb_uart_rx;

`ifdef UART_RX_MAJORITY_EN
    localparam int N_BIT = 6;
`else
    localparam int N_BIT = 5;
`endif
    localparam int T_BIT = N_BIT;

    logic       clk = 1'b0;
    logic       rst;
    logic       uart_rxd;
    logic [7:0] rx_data;
    logic       rx_perr;
    logic       rx_ferr;
    logic       rx_valid;
    logic       rx_ready;
    logic       sts_ovr;
    logic       sts_busy;

    int n_cmp  = 0;
    int n_fail = 0;

    // transfers and status pulses observed on the stream; only the monitor writes these
    logic [7:0] q_data[$];
    logic       q_perr[$];
    logic       q_ferr[$];
    int         ovr_cnt  = 0;
    int         busy_cnt = 0;

    always #5 clk = ~clk;

    uart_rx #(
        .BYTESIZE (8),
        .PARITY   ("ODD"),
        .STOPSIZE (1),
        .N_BIT    (N_BIT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .uart_rxd (uart_rxd),
        .rx_data  (rx_data),
        .rx_perr  (rx_perr),
        .rx_ferr  (rx_ferr),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .sts_ovr  (sts_ovr),
        .sts_busy (sts_busy)
    );

    // record transfers and count status cycles mid-cycle, away from the active edge
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (rx_valid && rx_ready) begin
                q_data.push_back(rx_data);
                q_perr.push_back(rx_perr);
                q_ferr.push_back(rx_ferr);
            end
            if (sts_ovr)  ovr_cnt++;
            if (sts_busy) busy_cnt++;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // one bit period; optionally invert the line for a single clk at offset glitch_at
    task automatic drive_bit(input logic b, input int glitch_at);
        for (int c = 0; c < T_BIT; c++) begin
            uart_rxd = (c == glitch_at) ? ~b : b;
            tick(1);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stp, input int gbit);
        drive_bit(1'b0, -1);
        for (int i = 0; i < 8; i++) begin
            drive_bit(d[i], (i == gbit) ? T_BIT / 2 : -1);
        end
        drive_bit(par, -1);
        drive_bit(stp, -1);
        uart_rxd = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1, "timeout");
    end

    initial begin
        int base;
        int ovr0;
        int busy0;

        rst      = 1'b0;
        uart_rxd = 1'b1;
        rx_ready = 1'b1;
        tick(3);
        chk("rst_data",  rx_data,  32'h0);
        chk("rst_valid", rx_valid, 32'h0);
        chk("rst_perr",  rx_perr,  32'h0);
        chk("rst_ferr",  rx_ferr,  32'h0);
        chk("rst_ovr",   sts_ovr,  32'h0);
        chk("rst_busy",  sts_busy, 32'h0);
        rst = 1'b1;
        tick(2 * T_BIT);
        ovr0 = ovr_cnt;

        // 'T' with correct odd parity (three ones -> parity bit 0)
        base = q_data.size();
        send_frame(8'h54, 1'b0, 1'b1, -1);
        tick(3 * T_BIT);
        chk("t1_count", q_data.size() - base, 1);
        chk("t1_data",  q_data[base], 8'h54);
        chk("t1_perr",  q_perr[base], 0);
        chk("t1_ferr",  q_ferr[base], 0);

        // 'H' has two ones, odd parity bit should be 1; send 0
        base = q_data.size();
        send_frame(8'h48, 1'b0, 1'b1, -1);
        tick(3 * T_BIT);
        chk("t2_count", q_data.size() - base, 1);
        chk("t2_data",  q_data[base], 8'h48);
        chk("t2_perr",  q_perr[base], 1);
        chk("t2_ferr",  q_ferr[base], 0);

        // 'e' with a low stop bit, then a clean 'l'
        base = q_data.size();
        send_frame(8'h65, 1'b1, 1'b0, -1);
        tick(2 * T_BIT);
        send_frame(8'h6C, 1'b1, 1'b1, -1);
        tick(3 * T_BIT);
        chk("t3_count",  q_data.size() - base, 2);
        chk("t3_e_data", q_data[base], 8'h65);
        chk("t3_e_perr", q_perr[base], 0);
        chk("t3_e_ferr", q_ferr[base], 1);
        chk("t3_l_data", q_data[base+1], 8'h6C);
        chk("t3_l_perr", q_perr[base+1], 0);
        chk("t3_l_ferr", q_ferr[base+1], 0);
        chk("t3_no_ovr", ovr_cnt - ovr0, 0);

        // consumer stalled: 'l' is held, back-to-back 'o' is dropped with one overrun pulse
        rx_ready = 1'b0;
        base = q_data.size();
        ovr0 = ovr_cnt;
        send_frame(8'h6C, 1'b1, 1'b1, -1);
        send_frame(8'h6F, 1'b1, 1'b1, -1);
        tick(3 * T_BIT);
        chk("t4_no_xfer", q_data.size() - base, 0);
        chk("t4_ovr",     ovr_cnt - ovr0, 1);
        chk("t4_valid",   rx_valid, 1);
        chk("t4_held",    rx_data, 8'h6C);
        rx_ready = 1'b1;
        tick(3);
        chk("t4_count",   q_data.size() - base, 1);
        chk("t4_data",    q_data[base], 8'h6C);
        chk("t4_drained", rx_valid, 0);

        // 2-clk low glitch: start is entered but rejected at mid start bit
        base  = q_data.size();
        busy0 = busy_cnt;
        uart_rxd = 1'b0;
        tick(2);
        uart_rxd = 1'b1;
        tick(3 * T_BIT);
        chk("t5_entered",  (busy_cnt - busy0) > 0, 1);
        chk("t5_busy_off", sts_busy, 0);
        chk("t5_no_xfer",  q_data.size() - base, 0);

        // reset in the middle of 'W' data bits, then 'd'
        base = q_data.size();
        ovr0 = ovr_cnt;
        drive_bit(1'b0, -1);
        drive_bit(1'b1, -1);
        drive_bit(1'b1, -1);
        drive_bit(1'b1, -1);
        chk("t6_busy_mid", sts_busy, 1);
        rst      = 1'b0;
        uart_rxd = 1'b1;
        tick(2);
        chk("t6_rst_data",  rx_data,  32'h0);
        chk("t6_rst_valid", rx_valid, 32'h0);
        chk("t6_rst_busy",  sts_busy, 32'h0);
        chk("t6_rst_ferr",  rx_ferr,  32'h0);
        rst = 1'b1;
        tick(2 * T_BIT);
        send_frame(8'h64, 1'b0, 1'b1, -1);
        tick(3 * T_BIT);
        chk("t6_count", q_data.size() - base, 1);
        chk("t6_data",  q_data[base], 8'h64);
        chk("t6_perr",  q_perr[base], 0);
        chk("t6_ferr",  q_ferr[base], 0);
        chk("t6_no_ovr", ovr_cnt - ovr0, 0);

`ifdef UART_RX_MAJORITY_EN
        // single-clk glitch in the middle of data bit 2 of 'W' is voted out
        base = q_data.size();
        send_frame(8'h57, 1'b0, 1'b1, 2);
        tick(3 * T_BIT);
        chk("m_count", q_data.size() - base, 1);
        chk("m_data",  q_data[base], 8'h57);
        chk("m_perr",  q_perr[base], 0);
        chk("m_ferr",  q_ferr[base], 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
